// File: rtl/layer_sequencer.sv
// Layer sequencer: latches a layer configuration on start_layer, walks filter groups and output
// rows issuing one row command per row over valid/ready, and pulses done_layer at the end.
module layer_sequencer #(
    parameter int unsigned FILTER_TILE = 16,
    parameter int unsigned ADDR_W      = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_layer,
    input  logic [8:0]        ifm_size,
    input  logic [10:0]       ifm_channel,
    input  logic [1:0]        kernel_size,
    input  logic [10:0]       num_filter,
    input  logic              maxpool_mode,
    input  logic [1:0]        maxpool_stride,
    input  logic              upsample_mode,
    input  logic [ADDR_W-1:0] start_read_addr,
    input  logic [ADDR_W-1:0] start_write_addr,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [8:0]        cmd_row,
    output logic [10:0]       cmd_filter_base,
    output logic [4:0]        cmd_filter_cnt,
    output logic [10:0]       cmd_channel,
    output logic [ADDR_W-1:0] cmd_rd_addr,
    output logic [ADDR_W-1:0] cmd_wr_base,
    input  logic              row_done,
    output logic              done_layer,
    output logic              busy,
    output logic [8:0]        ofm_size,
    output logic              cfg_err
);

    typedef enum logic [2:0] {StIdle, StSetup, StIssue, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [8:0]        ifm_size_q, ifm_size_d;
    logic [10:0]       ifm_channel_q, ifm_channel_d;
    logic [1:0]        kernel_size_q, kernel_size_d;
    logic [10:0]       num_filter_q, num_filter_d;
    logic              maxpool_mode_q, maxpool_mode_d;
    logic [1:0]        maxpool_stride_q, maxpool_stride_d;
    logic              upsample_mode_q, upsample_mode_d;
    logic [ADDR_W-1:0] rd_base_q, rd_base_d;
    logic [ADDR_W-1:0] wr_base_q, wr_base_d;
    logic [8:0]        conv_out_q, conv_out_d;
    logic [8:0]        ofm_size_q, ofm_size_d;
    logic [23:0]       area_q, area_d;
    logic [8:0]        row_q, row_d;
    logic [10:0]       filter_base_q, filter_base_d;
    logic              cfg_err_q, cfg_err_d;
    logic              busy_q, busy_d;
    logic              done_layer_q, done_layer_d;

    logic [8:0]  conv_out_w, pooled_w, ofm_w;
    logic        cfg_bad;
    logic [10:0] filters_left;

    // Derived geometry, evaluated from the latched config during SETUP.
    always_comb begin
        conv_out_w = ifm_size_q - 9'(kernel_size_q) + 9'd1;
        pooled_w   = (maxpool_mode_q && maxpool_stride_q == 2'd2) ? (conv_out_w >> 1) : conv_out_w;
        ofm_w      = upsample_mode_q ? (pooled_w << 1) : pooled_w;
        cfg_bad    = !(kernel_size_q == 2'd1 || kernel_size_q == 2'd3) ||
                     (ifm_size_q < 9'(kernel_size_q)) ||
                     (num_filter_q == 11'd0) ||
                     (maxpool_mode_q && !(maxpool_stride_q == 2'd1 || maxpool_stride_q == 2'd2));
    end

    always_comb begin
        state_d          = state_q;
        ifm_size_d       = ifm_size_q;
        ifm_channel_d    = ifm_channel_q;
        kernel_size_d    = kernel_size_q;
        num_filter_d     = num_filter_q;
        maxpool_mode_d   = maxpool_mode_q;
        maxpool_stride_d = maxpool_stride_q;
        upsample_mode_d  = upsample_mode_q;
        rd_base_d        = rd_base_q;
        wr_base_d        = wr_base_q;
        conv_out_d       = conv_out_q;
        ofm_size_d       = ofm_size_q;
        area_d           = area_q;
        row_d            = row_q;
        filter_base_d    = filter_base_q;
        cfg_err_d        = cfg_err_q;
        busy_d           = busy_q;
        done_layer_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_layer) begin
                    ifm_size_d       = ifm_size;
                    ifm_channel_d    = ifm_channel;
                    kernel_size_d    = kernel_size;
                    num_filter_d     = num_filter;
                    maxpool_mode_d   = maxpool_mode;
                    maxpool_stride_d = maxpool_stride;
                    upsample_mode_d  = upsample_mode;
                    rd_base_d        = start_read_addr;
                    wr_base_d        = start_write_addr;
                    cfg_err_d        = 1'b0;
                    busy_d           = 1'b1;
                    state_d          = StSetup;
                end
            end
            StSetup: begin
                conv_out_d    = conv_out_w;
                ofm_size_d    = ofm_w;
                area_d        = 24'(ofm_w) * 24'(ofm_w);
                row_d         = 9'd0;
                filter_base_d = 11'd0;
                if (cfg_bad) begin
                    cfg_err_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (cmd_ready) state_d = StWait;
            end
            StWait: begin
                if (row_done) begin
                    if ({1'b0, row_q} + 10'd1 < {1'b0, conv_out_q}) begin
                        row_d   = row_q + 9'd1;
                        state_d = StIssue;
                    end else if (12'(filter_base_q) + 12'(FILTER_TILE) < 12'(num_filter_q)) begin
                        row_d         = 9'd0;
                        filter_base_d = filter_base_q + 11'(FILTER_TILE);
                        state_d       = StIssue;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                done_layer_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            ifm_size_q       <= '0;
            ifm_channel_q    <= '0;
            kernel_size_q    <= '0;
            num_filter_q     <= '0;
            maxpool_mode_q   <= 1'b0;
            maxpool_stride_q <= '0;
            upsample_mode_q  <= 1'b0;
            rd_base_q        <= '0;
            wr_base_q        <= '0;
            conv_out_q       <= '0;
            ofm_size_q       <= '0;
            area_q           <= '0;
            row_q            <= '0;
            filter_base_q    <= '0;
            cfg_err_q        <= 1'b0;
            busy_q           <= 1'b0;
            done_layer_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            ifm_size_q       <= ifm_size_d;
            ifm_channel_q    <= ifm_channel_d;
            kernel_size_q    <= kernel_size_d;
            num_filter_q     <= num_filter_d;
            maxpool_mode_q   <= maxpool_mode_d;
            maxpool_stride_q <= maxpool_stride_d;
            upsample_mode_q  <= upsample_mode_d;
            rd_base_q        <= rd_base_d;
            wr_base_q        <= wr_base_d;
            conv_out_q       <= conv_out_d;
            ofm_size_q       <= ofm_size_d;
            area_q           <= area_d;
            row_q            <= row_d;
            filter_base_q    <= filter_base_d;
            cfg_err_q        <= cfg_err_d;
            busy_q           <= busy_d;
            done_layer_q     <= done_layer_d;
        end
    end

    // Command fields derive only from registers, so they hold steady while stalled in ISSUE.
    always_comb begin
        filters_left    = num_filter_q - filter_base_q;
        cmd_valid       = (state_q == StIssue);
        cmd_row         = row_q;
        cmd_filter_base = filter_base_q;
        cmd_filter_cnt  = (filters_left >= 11'(FILTER_TILE)) ? 5'(FILTER_TILE) : filters_left[4:0];
        cmd_channel     = ifm_channel_q;
        cmd_rd_addr     = ADDR_W'(24'(rd_base_q) + 24'(row_q) * 24'(ifm_size_q));
        cmd_wr_base     = ADDR_W'(24'(wr_base_q) + 24'(filter_base_q) * area_q);
        done_layer      = done_layer_q;
        busy            = busy_q;
        ofm_size        = ofm_size_q;
        cfg_err         = cfg_err_q;
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized bench for layer_sequencer: a list-based model of the expected command stream is
// compared against every accepted command, with random backpressure and row completion delay.
module tb_layer_sequencer;

    localparam int unsigned FT = 16;
    localparam int unsigned AW = 22;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_layer;
    logic [8:0]    ifm_size;
    logic [10:0]   ifm_channel;
    logic [1:0]    kernel_size;
    logic [10:0]   num_filter;
    logic          maxpool_mode;
    logic [1:0]    maxpool_stride;
    logic          upsample_mode;
    logic [AW-1:0] start_read_addr;
    logic [AW-1:0] start_write_addr;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [8:0]    cmd_row;
    logic [10:0]   cmd_filter_base;
    logic [4:0]    cmd_filter_cnt;
    logic [10:0]   cmd_channel;
    logic [AW-1:0] cmd_rd_addr;
    logic [AW-1:0] cmd_wr_base;
    logic          row_done;
    logic          done_layer;
    logic          busy;
    logic [8:0]    ofm_size;
    logic          cfg_err;

    layer_sequencer #(.FILTER_TILE(FT), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start_layer(start_layer), .ifm_size(ifm_size),
        .ifm_channel(ifm_channel), .kernel_size(kernel_size), .num_filter(num_filter),
        .maxpool_mode(maxpool_mode), .maxpool_stride(maxpool_stride),
        .upsample_mode(upsample_mode), .start_read_addr(start_read_addr),
        .start_write_addr(start_write_addr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_row(cmd_row), .cmd_filter_base(cmd_filter_base), .cmd_filter_cnt(cmd_filter_cnt),
        .cmd_channel(cmd_channel), .cmd_rd_addr(cmd_rd_addr), .cmd_wr_base(cmd_wr_base),
        .row_done(row_done), .done_layer(done_layer), .busy(busy), .ofm_size(ofm_size),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint row, base, cnt, ch, rd, wr;
    } cmd_t;

    typedef struct {
        int ifm, ch, k, nf, mp, st, up;
        longint rd, wr;
    } cfg_t;

    int   total = 0;
    int   bad   = 0;
    cmd_t exp_q[$];

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected command list straight from the layer arithmetic; returns config legality.
    function automatic bit model(input cfg_t c, output int ofm);
        int     conv;
        longint area;
        bit     legal;
        cmd_t   e;
        legal = (c.k == 1 || c.k == 3) && (c.ifm >= c.k) && (c.nf != 0) &&
                !(c.mp != 0 && !(c.st == 1 || c.st == 2));
        conv = c.ifm - c.k + 1;
        ofm  = (c.mp != 0 && c.st == 2) ? conv / 2 : conv;
        if (c.up != 0) ofm = ofm * 2;
        ofm  = ofm % 512;
        area = longint'(ofm) * ofm;
        exp_q.delete();
        if (legal) begin
            for (int b = 0; b < c.nf; b += FT) begin
                for (int r = 0; r < conv; r++) begin
                    e.row  = r;
                    e.base = b;
                    e.cnt  = (c.nf - b < FT) ? c.nf - b : FT;
                    e.ch   = c.ch;
                    e.rd   = (c.rd + longint'(r) * c.ifm) % (64'd1 << AW);
                    e.wr   = (c.wr + longint'(b) * area) % (64'd1 << AW);
                    exp_q.push_back(e);
                end
            end
        end
        return legal;
    endfunction

    task automatic drive_cfg(input cfg_t c);
        ifm_size         = 9'(c.ifm);
        ifm_channel      = 11'(c.ch);
        kernel_size      = 2'(c.k);
        num_filter       = 11'(c.nf);
        maxpool_mode     = 1'(c.mp);
        maxpool_stride   = 2'(c.st);
        upsample_mode    = 1'(c.up);
        start_read_addr  = AW'(c.rd);
        start_write_addr = AW'(c.wr);
    endtask

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.ifm = $urandom_range(1, 24);
        c.ch  = $urandom_range(0, 2047);
        c.k   = $urandom_range(0, 3);
        c.nf  = $urandom_range(0, 40);
        c.mp  = $urandom_range(0, 1);
        c.st  = $urandom_range(0, 3);
        c.up  = $urandom_range(0, 1);
        c.rd  = $urandom_range(0, (1 << AW) - 1);
        c.wr  = $urandom_range(0, (1 << AW) - 1);
        return c;
    endfunction

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_valid"}, cmd_valid, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done_layer, 0);
        check_eq({tag, "_ofm"}, ofm_size, 0);
        check_eq({tag, "_err"}, cfg_err, 0);
        check_eq({tag, "_row"}, cmd_row, 0);
        check_eq({tag, "_cnt"}, cmd_filter_cnt, 0);
        check_eq({tag, "_ch"}, cmd_channel, 0);
        check_eq({tag, "_rd"}, cmd_rd_addr, 0);
        check_eq({tag, "_wr"}, cmd_wr_base, 0);
    endtask

    task automatic run_layer(input cfg_t c, input bit stall, input int busy_start_at,
                             input int rst_at, output int n_cmds, output cmd_t last);
        int   ofm, dly, stall_left, last_fire, exp_total;
        bit   legal, done_seen, pend, stalled, acc;
        cmd_t snap, got, e;
        legal      = model(c, ofm);
        exp_total  = exp_q.size();
        n_cmds     = 0;
        done_seen  = 0;
        pend       = 0;
        stalled    = 0;
        dly        = 0;
        last_fire  = -10;
        stall_left = stall ? 10 : 0;
        last       = '{default: 0};
        @(negedge clk);
        drive_cfg(c);
        start_layer = 1'b1;
        row_done    = 1'b0;
        cmd_ready   = 1'b0;
        for (int k = 1; k <= 6000; k++) begin
            @(negedge clk);
            start_layer = 1'b0;
            row_done    = 1'b0;
            acc         = 0;
            if (k == busy_start_at) begin
                drive_cfg(rand_cfg());
                start_layer = 1'b1;
            end
            if (rst_at != 0 && k == rst_at) begin
                rst       = 1'b1;
                cmd_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check_idle_zero("midrst");
                repeat (4) begin
                    @(negedge clk);
                    check_eq("midrst_no_done", done_layer, 0);
                    check_eq("midrst_no_valid", cmd_valid, 0);
                end
                return;
            end
            if (k == 1) begin
                check_eq("setup_busy", busy, 1);
                check_eq("setup_valid", cmd_valid, 0);
            end
            if (k == 2) begin
                check_eq("cfg_err", cfg_err, !legal);
                check_eq("first_valid_lat", cmd_valid, legal);
                if (legal) check_eq("ofm_size", ofm_size, ofm);
            end
            if (done_layer) begin
                done_seen = 1;
                check_eq("done_busy_low", busy, 0);
                check_eq("done_cmds_left", exp_q.size(), 0);
                check_eq("done_cmd_total", n_cmds, exp_total);
                if (legal) check_eq("done_after_last_row", k, last_fire + 2);
                else check_eq("err_done_lat", k, 3);
                break;
            end
            if (cmd_valid) begin
                check_eq("one_outstanding", pend, 0);
                got = '{cmd_row, cmd_filter_base, cmd_filter_cnt, cmd_channel,
                        cmd_rd_addr, cmd_wr_base};
                if (stalled) begin
                    check_eq("hold_row", got.row, snap.row);
                    check_eq("hold_base", got.base, snap.base);
                    check_eq("hold_cnt", got.cnt, snap.cnt);
                    check_eq("hold_rd", got.rd, snap.rd);
                    check_eq("hold_wr", got.wr, snap.wr);
                end
                if (stall_left > 0) begin
                    cmd_ready = 1'b0;
                    stall_left--;
                end else begin
                    cmd_ready = ($urandom_range(0, 3) != 0);
                end
                if (cmd_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("cmd_count_exceeded", n_cmds + 1, exp_total);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("cmd_row", got.row, e.row);
                        check_eq("cmd_base", got.base, e.base);
                        check_eq("cmd_cnt", got.cnt, e.cnt);
                        check_eq("cmd_ch", got.ch, e.ch);
                        check_eq("cmd_rd", got.rd, e.rd);
                        check_eq("cmd_wr", got.wr, e.wr);
                    end
                    n_cmds++;
                    last    = got;
                    pend    = 1;
                    dly     = $urandom_range(1, 4);
                    stalled = 0;
                    acc     = 1;
                end else begin
                    stalled = 1;
                    snap    = got;
                end
                // Stray completion while the command is still being offered.
                if ($urandom_range(0, 3) == 0) row_done = 1'b1;
            end else begin
                if (stalled) check_eq("valid_dropped", cmd_valid, 1);
                stalled   = 0;
                cmd_ready = 1'($urandom_range(0, 1));
            end
            if (pend && !acc) begin
                dly--;
                if (dly == 0) begin
                    row_done  = 1'b1;
                    pend      = 0;
                    last_fire = k;
                end
            end
        end
        check_eq("done_seen", done_seen, 1);
        row_done  = 1'b0;
        cmd_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("done_single_cycle", done_layer, 0);
            check_eq("idle_busy", busy, 0);
        end
    endtask

    initial begin
        cfg_t c;
        cmd_t last;
        int   n;
        rst = 1'b1;
        start_layer = 1'b0;
        cmd_ready = 1'b0;
        row_done = 1'b0;
        drive_cfg('{default: 0});
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;

        c = '{ifm: 318, ch: 64, k: 3, nf: 16, mp: 1, st: 2, up: 0, rd: 0, wr: 0};
        run_layer(c, 1, 7, 0, n, last);
        check_eq("t1_ncmd", n, 316);

        c = '{ifm: 13, ch: 512, k: 1, nf: 255, mp: 0, st: 0, up: 0, rd: 1234, wr: 1730560};
        run_layer(c, 0, 0, 0, n, last);
        check_eq("t2_ncmd", n, 208);
        check_eq("t2_last_base", last.base, 240);
        check_eq("t2_last_cnt", last.cnt, 15);
        check_eq("t2_last_wr", last.wr, 1771120);

        c = '{ifm: 13, ch: 3, k: 1, nf: 128, mp: 0, st: 0, up: 1, rd: 100, wr: 200};
        run_layer(c, 0, 0, 0, n, last);
        check_eq("t3_ncmd", n, 104);

        c = '{ifm: 8, ch: 7, k: 3, nf: 20, mp: 1, st: 1, up: 0, rd: 5, wr: 9};
        run_layer(c, 1, 0, 0, n, last);
        check_eq("t4_ncmd", n, 12);

        c = '{ifm: 10, ch: 7, k: 2, nf: 5, mp: 0, st: 0, up: 0, rd: 5, wr: 9};
        run_layer(c, 0, 2, 0, n, last);
        check_eq("t5_ncmd", n, 0);

        c = '{ifm: 318, ch: 64, k: 3, nf: 16, mp: 1, st: 2, up: 0, rd: 77, wr: 88};
        run_layer(c, 0, 0, 40, n, last);
        c = '{ifm: 8, ch: 9, k: 3, nf: 33, mp: 0, st: 0, up: 0, rd: 11, wr: 22};
        run_layer(c, 0, 0, 0, n, last);
        check_eq("t6_ncmd", n, 18);

        for (int i = 0; i < 8; i++) begin
            run_layer(rand_cfg(), 1'($urandom_range(0, 1)), 0, 0, n, last);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
